// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 field layout, special encodings and block widths shared by the MAC datapath.
`default_nettype none
package fp16_pkg;
   localparam int DATA_WIDTH    = 16;
   localparam int CLK_NUM_WIDTH = 8;
   localparam int EXP_W         = 5;
   localparam int MAN_W         = 10;
   localparam int BIAS          = 15;

   localparam logic [15:0] QNAN = 16'h7E00;
   localparam logic [15:0] PINF = 16'h7C00;

   function automatic logic [15:0] fp16_inf(input logic sign);
      return {sign, PINF[14:0]};
   endfunction
endpackage
`default_nettype wire

// File: rtl/mult_add_unit_float16_if.sv
// mult_add_unit_float16_if: operand stream in, windowed dot-product result out.
`default_nettype none
interface mult_add_unit_float16_if #(
   parameter int DATA_WIDTH    = fp16_pkg::DATA_WIDTH,
   parameter int CLK_NUM_WIDTH = fp16_pkg::CLK_NUM_WIDTH
);
   logic [DATA_WIDTH-1:0]    mult_a;
   logic [DATA_WIDTH-1:0]    mult_b;
   logic [CLK_NUM_WIDTH-1:0] clk_num;
   logic                     result_ready;
   logic [DATA_WIDTH-1:0]    mult_add_result;

   modport master (
      output mult_a, mult_b, clk_num,
      input  result_ready, mult_add_result
   );

   modport slave (
      input  mult_a, mult_b, clk_num,
      output result_ready, mult_add_result
   );
endinterface
`default_nettype wire

// File: rtl/fp16_adder.sv
// fp16_adder: combinational binary16 add, round-to-nearest-even, subnormals flushed to zero.
`default_nettype none
module fp16_adder
   import fp16_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   logic             sign_a, sign_b, sgn_g, sgn_s;
   logic [EXP_W-1:0] exp_a, exp_b, exp_g, exp_s, diff;
   logic [MAN_W-1:0] man_a, man_b, man_g, man_s;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, found;
   logic [13:0]      mant_g, mant_s, mant_sh, mask;
   logic [14:0]      raw;
   logic [12:0]      norm;
   logic [3:0]       lz;
   logic [10:0]      rnd;
   logic signed [7:0] res_exp;

   assign sign_a = a[15];
   assign exp_a  = a[14:10];
   assign man_a  = a[9:0];
   assign sign_b = b[15];
   assign exp_b  = b[14:10];
   assign man_b  = b[9:0];

   always_comb begin
      a_zero = (exp_a == '0);
      b_zero = (exp_b == '0);
      a_inf  = (exp_a == '1) && (man_a == '0);
      b_inf  = (exp_b == '1) && (man_b == '0);
      a_nan  = (exp_a == '1) && (man_a != '0);
      b_nan  = (exp_b == '1) && (man_b != '0);

      swap  = {exp_b, man_b} > {exp_a, man_a};
      sgn_g = swap ? sign_b : sign_a;
      sgn_s = swap ? sign_a : sign_b;
      exp_g = swap ? exp_b  : exp_a;
      exp_s = swap ? exp_a  : exp_b;
      man_g = swap ? man_b  : man_a;
      man_s = swap ? man_a  : man_b;
      diff  = exp_g - exp_s;

      // Three extra low bits (guard/round/sticky) keep RNE exact through subtraction.
      mant_g  = {1'b1, man_g, 3'b000};
      mant_s  = {1'b1, man_s, 3'b000};
      mask    = (14'd1 << diff) - 14'd1;
      mant_sh = (diff > 5'd13) ? 14'd1
              : ((mant_s >> diff) | {13'd0, |(mant_s & mask)});
      raw     = (sgn_g ^ sgn_s) ? ({1'b0, mant_g} - {1'b0, mant_sh})
                                : ({1'b0, mant_g} + {1'b0, mant_sh});

      lz    = '0;
      found = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found && raw[i]) begin
            lz    = 4'(13 - i);
            found = 1'b1;
         end
      end

      res_exp = $signed({3'b000, exp_g});
      if (raw[14]) begin
         norm    = {raw[13:2], raw[1] | raw[0]};
         res_exp = res_exp + 8'sd1;
      end else begin
         norm    = 13'(raw[13:0] << lz);
         res_exp = res_exp - $signed({4'b0000, lz});
      end

      rnd = {1'b0, norm[12:3]} + 11'(norm[2] & (norm[1] | norm[0] | norm[3]));
      if (rnd[10])
         res_exp = res_exp + 8'sd1;

      if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b)))
         sum = QNAN;
      else if (a_inf)
         sum = a;
      else if (b_inf)
         sum = b;
      else if (a_zero && b_zero)
         sum = {sign_a & sign_b, 15'd0};
      else if (a_zero)
         sum = b;
      else if (b_zero)
         sum = a;
      else if (raw == '0)
         sum = 16'h0000;
      else if (res_exp >= 8'sd31)
         sum = fp16_inf(sgn_g);
      else if (res_exp <= 8'sd0)
         sum = {sgn_g, 15'd0};
      else
         sum = {sgn_g, res_exp[4:0], rnd[9:0]};
   end
endmodule
`default_nettype wire

// File: rtl/mult_add_unit_float16.sv
// mult_add_unit_float16: streaming FP16 multiply then accumulate over clk_num-sample windows.
`default_nettype none
module mult_add_unit_float16 #(
   parameter int DATA_WIDTH    = fp16_pkg::DATA_WIDTH,
   parameter int CLK_NUM_WIDTH = fp16_pkg::CLK_NUM_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   mult_add_unit_float16_if.slave  bus
);
   import fp16_pkg::*;

   logic             sign_a, sign_b, mul_sign;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] man_a, man_b, mul_frac;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, guard, sticky;
   logic [21:0]      mant_prod;
   logic [10:0]      mul_rnd;
   logic signed [7:0] mul_exp;
   logic [DATA_WIDTH-1:0] mul_res;

   logic [CLK_NUM_WIDTH-1:0] cnt, n_lat, n_eff;
   logic                     first, last;
   logic [DATA_WIDTH-1:0]    prod, acc, add_sum, result;
   logic                     p1_first, p1_last, p2_last, ready;

   assign sign_a = bus.mult_a[15];
   assign exp_a  = bus.mult_a[14:10];
   assign man_a  = bus.mult_a[9:0];
   assign sign_b = bus.mult_b[15];
   assign exp_b  = bus.mult_b[14:10];
   assign man_b  = bus.mult_b[9:0];

   always_comb begin
      a_zero   = (exp_a == '0);
      b_zero   = (exp_b == '0);
      a_inf    = (exp_a == '1) && (man_a == '0);
      b_inf    = (exp_b == '1) && (man_b == '0);
      a_nan    = (exp_a == '1) && (man_a != '0);
      b_nan    = (exp_b == '1) && (man_b != '0);
      mul_sign = sign_a ^ sign_b;

      mant_prod = 22'({1'b1, man_a}) * 22'({1'b1, man_b});
      mul_exp   = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b}) - $signed(8'(BIAS));

      // Product of two [1,2) significands lies in [1,4); renormalise the [2,4) half.
      if (mant_prod[21]) begin
         mul_frac = mant_prod[20:11];
         guard    = mant_prod[10];
         sticky   = |mant_prod[9:0];
         mul_exp  = mul_exp + 8'sd1;
      end else begin
         mul_frac = mant_prod[19:10];
         guard    = mant_prod[9];
         sticky   = |mant_prod[8:0];
      end

      mul_rnd = {1'b0, mul_frac} + 11'(guard & (sticky | mul_frac[0]));
      if (mul_rnd[10])
         mul_exp = mul_exp + 8'sd1;

      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         mul_res = QNAN;
      else if (a_inf || b_inf)
         mul_res = fp16_inf(mul_sign);
      else if (a_zero || b_zero)
         mul_res = {mul_sign, 15'd0};
      else if (mul_exp >= 8'sd31)
         mul_res = fp16_inf(mul_sign);
      else if (mul_exp <= 8'sd0)
         mul_res = {mul_sign, 15'd0};
      else
         mul_res = {mul_sign, mul_exp[4:0], mul_rnd[9:0]};
   end

   // Window length is taken from clk_num only on the first sample; 0 behaves as 1.
   always_comb begin
      first = (cnt == '0);
      if (first)
         n_eff = (bus.clk_num == '0) ? CLK_NUM_WIDTH'(1) : bus.clk_num;
      else
         n_eff = n_lat;
      last = (cnt == n_eff - CLK_NUM_WIDTH'(1));
   end

   fp16_adder u_adder (
      .a   (acc),
      .b   (prod),
      .sum (add_sum)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         n_lat    <= '0;
         prod     <= '0;
         p1_first <= 1'b0;
         p1_last  <= 1'b0;
         acc      <= '0;
         p2_last  <= 1'b0;
         result   <= '0;
         ready    <= 1'b0;
      end else begin
         if (first)
            n_lat <= n_eff;
         cnt      <= last ? '0 : cnt + CLK_NUM_WIDTH'(1);
         prod     <= mul_res;
         p1_first <= first;
         p1_last  <= last;
         acc      <= p1_first ? prod : add_sum;
         p2_last  <= p1_last;
         ready    <= p2_last;
         if (p2_last)
            result <= acc;
      end
   end

   assign bus.result_ready    = ready;
   assign bus.mult_add_result = result;
endmodule
`default_nettype wire

// File: tb/tb_mult_add_unit_float16.sv
// tb_mult_add_unit_float16: vector table streamed back-to-back, results checked through a timed scoreboard.
`default_nettype none
module tb_mult_add_unit_float16;
   typedef struct {
      logic [7:0]       n;
      int               len;
      logic [3:0][15:0] a;
      logic [3:0][15:0] b;
      logic [15:0]      exp;
      string            name;
   } vec_t;

   typedef struct {
      logic [15:0] exp;
      int          due;
      string       name;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult_add_unit_float16_if #(.DATA_WIDTH(16), .CLK_NUM_WIDTH(8)) bus ();

   mult_add_unit_float16 #(.DATA_WIDTH(16), .CLK_NUM_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   vec_t vecs[$];
   sb_t  sbq[$];
   int   cyc        = 0;
   int   compared   = 0;
   int   mismatched = 0;
   bit   mon_en     = 1'b0;
   bit   strict     = 1'b1;
   bit   exp_rdy;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: mult_add_result got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: result_ready got %b expected %b (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic add_vec(input logic [7:0] n, input int len,
                          input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3,
                          input logic [15:0] e, input string nm);
      vec_t v;
      v.n = n; v.len = len;
      v.a = {a3, a2, a1, a0};
      v.b = {b3, b2, b1, b0};
      v.exp = e; v.name = nm;
      vecs.push_back(v);
   endtask

   // Inputs change at negedge; the next posedge samples them and the sum shows two edges later.
   task automatic drive(input logic [7:0] n, input logic [15:0] a, input logic [15:0] b,
                        input bit push, input logic [15:0] e, input string nm);
      sb_t s;
      @(negedge clk);
      bus.clk_num = n;
      bus.mult_a  = a;
      bus.mult_b  = b;
      if (push) begin
         s.exp = e; s.due = cyc + 3; s.name = nm;
         sbq.push_back(s);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         exp_rdy = (sbq.size() > 0) && (sbq[0].due == cyc);
         if (exp_rdy || strict)
            check1("ready_timing", bus.result_ready, exp_rdy);
         if (exp_rdy) begin
            check16(sbq[0].name, bus.mult_add_result, sbq[0].exp);
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      int g;
      bus.mult_a  = 16'h0000;
      bus.mult_b  = 16'h0000;
      bus.clk_num = 8'd1;
      #1 rst = 1'b0;
      #2;
      check1("reset_ready_async", bus.result_ready, 1'b0);
      check16("reset_result_async", bus.mult_add_result, 16'h0000);

      add_vec(8'd4, 4, 16'h3C00, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4200, 16'h3C00, 16'h4000, 16'h4B00, "n4_sum14");
      add_vec(8'd2, 2, 16'h3C00, 16'h4000, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4600, "n2_sum6");
      add_vec(8'd2, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, "n2_zeros");
      add_vec(8'd2, 2, 16'hC000, 16'h4000, 16'h4400, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, "cancel_pos_zero");
      add_vec(8'd1, 1, 16'h7BFF, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7C00, "mul_overflow");
      add_vec(8'd1, 1, 16'h7C00, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7E00, "inf_times_zero");
      add_vec(8'd1, 1, 16'h7E00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7E00, "nan_operand");
      add_vec(8'd2, 2, 16'h7C00, 16'h3C00, 16'hFC00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7E00, "inf_minus_inf");
      add_vec(8'd2, 2, 16'h8000, 16'h3C00, 16'h8000, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, "neg_zero_sum");
      add_vec(8'd1, 1, 16'h3C01, 16'h3C01, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3C02, "mul_round");
      add_vec(8'd1, 1, 16'h0400, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, "mul_underflow");
      add_vec(8'd1, 1, 16'h0001, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, "subnormal_in");
      add_vec(8'd3, 3, 16'h7BFF, 16'h3C00, 16'h7BFF, 16'h3C00, 16'hFBFF, 16'h3C00, 16'h0, 16'h0, 16'h7C00, "seq_overflow");
      add_vec(8'd2, 2, 16'h3C00, 16'h3C00, 16'h1000, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3C00, "add_tie_even_down");
      add_vec(8'd2, 2, 16'h3C01, 16'h3C00, 16'h1000, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3C02, "add_tie_even_up");
      add_vec(8'd2, 2, 16'h4200, 16'h3C00, 16'hBC00, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3C00, "sub_normalize");
      add_vec(8'd0, 1, 16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4400, "clk_num_zero");
      add_vec(8'd3, 3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 16'h4200, "n3_ones");
      add_vec(8'd1, 1, 16'hC000, 16'h4200, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hC600, "neg_product");

      @(posedge clk);
      @(negedge clk);
      check1("reset_ready_held", bus.result_ready, 1'b0);
      check16("reset_result_held", bus.mult_add_result, 16'h0000);

      @(posedge clk);
      #1 rst = 1'b1;
      mon_en = 1'b1;

      foreach (vecs[k]) begin
         for (int i = 0; i < vecs[k].len; i++)
            drive(vecs[k].n, vecs[k].a[i], vecs[k].b[i], i == vecs[k].len - 1, vecs[k].exp, vecs[k].name);
      end

      // clk_num drops to 2 after the first sample: this window still takes 4 products.
      drive(8'd4, 16'h3C00, 16'h3C00, 1'b0, 16'h0, "");
      drive(8'd2, 16'h3C00, 16'h3C00, 1'b0, 16'h0, "");
      drive(8'd2, 16'h3C00, 16'h3C00, 1'b0, 16'h0, "");
      drive(8'd2, 16'h3C00, 16'h3C00, 1'b1, 16'h4400, "nchange_keep4");
      drive(8'd2, 16'h3C00, 16'h3C00, 1'b0, 16'h0, "");
      drive(8'd2, 16'h3C00, 16'h3C00, 1'b1, 16'h4000, "nchange_next2");

      // Abort a window after two of four products.
      drive(8'd4, 16'h4000, 16'h4000, 1'b0, 16'h0, "");
      drive(8'd4, 16'h4000, 16'h4000, 1'b0, 16'h0, "");
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check1("midreset_ready", bus.result_ready, 1'b0);
      check16("midreset_result", bus.mult_add_result, 16'h0000);
      compared++;
      if (sbq.size() != 0) begin
         mismatched++;
         $display("FAIL midreset_pending: outstanding results got %0d expected 0", sbq.size());
         sbq.delete();
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check16("post_reset_result", bus.mult_add_result, 16'h0000);
      for (int i = 0; i < 4; i++)
         drive(8'd4, 16'h3C00, 16'h3C00, i == 3, 16'h4400, "post_reset_window");
      drive(8'd2, 16'h4000, 16'h4000, 1'b0, 16'h0, "");
      drive(8'd2, 16'h4000, 16'h4000, 1'b1, 16'h4800, "post_reset_n2");

      strict = 1'b0;
      g = 0;
      while (sbq.size() > 0 && g < 20) begin
         @(negedge clk);
         g++;
      end
      #1;
      compared++;
      if (sbq.size() != 0) begin
         mismatched++;
         $display("FAIL drain_timeout: outstanding results got %0d expected 0", sbq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
